// File: rtl/mux_pipe_n.sv
// Registered N-way selector with valid/ready handshake. A 2-entry skid buffer
// keeps every output registered, so select timing never chains downstream.
module mux_pipe_n #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] d,
  input  logic [SEL_W-1:0]        s,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        y,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    err_clr,
  output logic                    sel_err
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t                         state;
  logic [WIDTH-1:0]               skid;
  logic [NUM_IN-1:0][WIDTH-1:0]   lane;
  logic [WIDTH-1:0]               cap;
  logic                           oor;
  logic                           accept;
  logic                           fire;

  // One-hot AND-OR select: an out-of-range s matches no lane and yields zero.
  for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
    assign lane[i] = (s == SEL_W'(i)) ? d[i*WIDTH +: WIDTH] : '0;
  end

  always_comb begin
    cap = '0;
    for (int i = 0; i < NUM_IN; i++) cap = cap | lane[i];
  end

  if (NUM_IN >= (1 << SEL_W)) begin : g_no_oor
    assign oor = 1'b0;
  end else begin : g_oor
    localparam logic [SEL_W:0] NUM_W = (SEL_W+1)'(NUM_IN);
    assign oor = ({1'b0, s} >= NUM_W);
  end

  assign accept = in_valid && in_ready;
  assign fire   = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      y         <= '0;
      skid      <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      sel_err   <= 1'b0;
    end else begin
      if (accept && oor) sel_err <= 1'b1;
      else if (err_clr)  sel_err <= 1'b0;

      case (state)
        EMPTY: if (accept) begin
          y         <= cap;
          out_valid <= 1'b1;
          state     <= ONE;
        end
        ONE: begin
          if (accept && fire) begin
            y <= cap;
          end else if (accept) begin
            skid     <= cap;
            in_ready <= 1'b0;
            state    <= TWO;
          end else if (fire) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        TWO: if (fire) begin
          y        <= skid;
          in_ready <= 1'b1;
          state    <= ONE;
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= EMPTY;
        end
      endcase
    end
  end

endmodule
